incline_filter: RTL and testbench
=================================

INCLINE_FILTER -- requirements
Module: incline_filter

Interface
REQ-001 SHALL provide parameter IN_W, default 13, width of the signed raw incline input.
REQ-002 SHALL provide parameter OUT_W, default 10, width of the signed saturated/filtered output; OUT_W < IN_W.
REQ-003 SHALL provide parameter AVG_LOG2, default 2, log2 of the moving-average window depth (window N = 2^AVG_LOG2, AVG_LOG2 range 1..4).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of the filter history.
REQ-007 SHALL have port in_vld  input  1  a new incline sample is present this cycle.
REQ-008 SHALL have port incline  input  IN_W  signed two's-complement raw sample.
REQ-009 SHALL have port out_vld  output  1  one-cycle strobe, new filtered result valid.
REQ-010 SHALL have port incline_filt  output  OUT_W  signed filtered incline.
REQ-011 SHALL have ports sat_hi, sat_lo  output  1 each  the current output's sample clipped at max/min.
REQ-012 SHALL have port full  output  1  window holds N real samples since reset or clr.

Function
REQ-013 SHALL saturate each sample to signed OUT_W: above 2^(OUT_W-1)-1 -> max; below -2^(OUT_W-1) -> min; otherwise incline[OUT_W-1:0].
REQ-014 SHALL store saturated samples in an N-entry circular buffer with a write pointer that wraps from N-1 to 0.
REQ-015 SHALL keep a running sum of width OUT_W+AVG_LOG2: on in_vld, sum <= sum + new - oldest (oldest = entry overwritten); no overflow possible.
REQ-016 SHALL drive incline_filt <= (sum + new - oldest) >>> AVG_LOG2 (arithmetic shift, truncation toward minus infinity), registered.
REQ-017 SHALL assert out_vld exactly one cycle after each accepted in_vld (latency 1); back-to-back in_vld yields back-to-back out_vld.
REQ-018 SHALL register sat_hi/sat_lo alongside the result; both never high together.
REQ-019 SHALL implement FSM FILL/RUN: FILL after reset/clr; FILL->RUN on the Nth accepted sample; RUN persists until clr.
REQ-020 SHALL drive full = (state == RUN), updating in the same cycle as the out_vld for the Nth sample.
REQ-021 SHALL treat buffer entries as zero during FILL, so outputs ramp toward the input.
REQ-022 SHALL, on clr, zero buffer, sum, pointer, incline_filt, sat flags; go to FILL; clr overrides simultaneous in_vld (sample dropped, no out_vld next cycle).
REQ-023 SHALL hold incline_filt and flags between strobes.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear out_vld, incline_filt, sat_hi, sat_lo, full, sum, pointer, buffer; state FILL.
REQ-025 SHALL ignore in_vld while rst_n low; first sample after deassertion is treated as sample 1 of FILL.

Configuration
REQ-026 SHALL, with macro INCLINE_FILTER_SAT_STAT_EN defined, add output sat_cnt (16 bits) counting accepted saturated samples, saturating at 16'hFFFF, cleared by rst_n and clr.
REQ-027 SHALL, without INCLINE_FILTER_SAT_STAT_EN, omit sat_cnt port and counter logic entirely; all other behaviour identical.

Structure
REQ-028 SHALL place FSM state typedef (FILL, RUN) and default width constants (IN_W 13, OUT_W 10, AVG_LOG2 2) in shared package incline_pkg.
REQ-029 SHALL implement saturation (REQ-013) as combinational sub-module incline_sat_param, parameterised by IN_W/OUT_W, outputs value, hi, lo.

Verification (defaults)
REQ-030 SHALL check reset: rst_n low mid-stream -> all outputs 0, full 0 immediately, no clk edge required.
REQ-031 SHALL check ramp: four in_vld with incline=100 -> incline_filt 25, 50, 75, 100; full rises with 4th out_vld.
REQ-032 SHALL check positive clip: incline=13'h0FFF x4 -> sat_hi=1 each, final incline_filt=511.
REQ-033 SHALL check negative clip: incline=13'h1000 (-4096) x4 -> sat_lo=1, final incline_filt=-512; incline=-600 then -> sat_lo=1.
REQ-034 SHALL check clr collision: in RUN, clr with in_vld=1, incline=200 -> no out_vld, full 0, incline_filt 0; next sample 200 -> 50.
REQ-035 SHALL check stats build: with INCLINE_FILTER_SAT_STAT_EN, 3 clipped + 2 in-range samples -> sat_cnt=3; clr -> 0.

Source files
------------

// File: rtl/incline_pkg.sv
// Shared types and default widths for the incline filter slice.
package incline_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int IN_W_DEF     = 13;
  localparam int OUT_W_DEF    = 10;
  localparam int AVG_LOG2_DEF = 2;

endpackage

// File: rtl/incline_sat_param.sv
// Combinational clip of a signed IN_W sample into the signed OUT_W range.
module incline_sat_param
  import incline_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] value,
  output logic             hi,
  output logic             lo
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (OUT_W - 1)));

  always_comb begin
    hi = ($signed(din) > MAX_V);
    lo = ($signed(din) < MIN_V);
    if (hi) begin
      value = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (lo) begin
      value = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      value = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/incline_filter.sv
// Saturating moving-average filter for the raw incline sample stream.
// Define INCLINE_FILTER_SAT_STAT_EN to add the sat_cnt clipped-sample counter.
module incline_filter
  import incline_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [IN_W-1:0]  incline,
  output logic             out_vld,
  output logic [OUT_W-1:0] incline_filt,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             full
`ifdef INCLINE_FILTER_SAT_STAT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = OUT_W + AVG_LOG2;

  logic [OUT_W-1:0] sat_val;
  logic             sat_hi_c;
  logic             sat_lo_c;

  incline_sat_param #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .din  (incline),
    .value(sat_val),
    .hi   (sat_hi_c),
    .lo   (sat_lo_c)
  );

  state_t                   state_q, state_d;
  logic [AVG_LOG2-1:0]      ptr_q, ptr_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [OUT_W-1:0]         buf_q [N];
  logic [OUT_W-1:0]         buf_d [N];
  logic [OUT_W-1:0]         filt_q, filt_d;
  logic                     hi_q, hi_d;
  logic                     lo_q, lo_d;
  logic                     vld_q, vld_d;

  logic [OUT_W-1:0]         oldest;
  logic signed [SUM_W-1:0]  new_ext;
  logic signed [SUM_W-1:0]  old_ext;
  logic signed [SUM_W-1:0]  sum_next;

  // During FILL the slot being overwritten never held a real sample, so it counts as zero.
  always_comb begin
    oldest   = (state_q == RUN) ? buf_q[ptr_q] : '0;
    new_ext  = {{AVG_LOG2{sat_val[OUT_W-1]}}, sat_val};
    old_ext  = {{AVG_LOG2{oldest[OUT_W-1]}}, oldest};
    sum_next = sum_q + new_ext - old_ext;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    buf_d   = buf_q;
    filt_d  = filt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    vld_d   = 1'b0;
    if (clr) begin
      state_d = FILL;
      ptr_d   = '0;
      sum_d   = '0;
      filt_d  = '0;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
      for (int i = 0; i < N; i++) buf_d[i] = '0;
    end else if (in_vld) begin
      buf_d[ptr_q] = sat_val;
      ptr_d        = ptr_q + 1'b1;
      sum_d        = sum_next;
      // Dropping the low AVG_LOG2 bits of the signed sum is the floor division by N.
      filt_d       = sum_next[SUM_W-1:AVG_LOG2];
      hi_d         = sat_hi_c;
      lo_d         = sat_lo_c;
      vld_d        = 1'b1;
      if ((state_q == FILL) && (ptr_q == AVG_LOG2'(N - 1))) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      ptr_q   <= '0;
      sum_q   <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      filt_q  <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      buf_q   <= buf_d;
      filt_q  <= filt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      vld_q   <= vld_d;
    end
  end

  assign out_vld      = vld_q;
  assign incline_filt = filt_q;
  assign sat_hi       = hi_q;
  assign sat_lo       = lo_q;
  assign full         = (state_q == RUN);

`ifdef INCLINE_FILTER_SAT_STAT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr) begin
      sat_cnt_d = '0;
    end else if (in_vld && (sat_hi_c || sat_lo_c) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_incline_filter.sv
// Scoreboard bench for incline_filter: a reference model queues each expected
// strobe as stimulus is driven and the monitor compares it when out_vld fires.
module tb_incline_filter;

  localparam int IN_W  = 13;
  localparam int OUT_W = 10;
  localparam int N     = 4;
  localparam int MAXV  = 511;
  localparam int MINV  = -512;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_vld;
  logic [IN_W-1:0]  incline;
  logic             out_vld;
  logic [OUT_W-1:0] incline_filt;
  logic             sat_hi;
  logic             sat_lo;
  logic             full;
`ifdef INCLINE_FILTER_SAT_STAT_EN
  logic [15:0]      sat_cnt;
`endif

  incline_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_vld      (in_vld),
    .incline     (incline),
    .out_vld     (out_vld),
    .incline_filt(incline_filt),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo),
    .full        (full)
`ifdef INCLINE_FILTER_SAT_STAT_EN
    ,
    .sat_cnt     (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int filt;
    int hi;
    int lo;
    int full;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   testCount = 0;
  int   failCount = 0;

  int   modelBuf [N];
  int   modelPtr;
  int   modelCount;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int satModel(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < N; i++) modelBuf[i] = 0;
    modelPtr   = 0;
    modelCount = 0;
  endtask

  task automatic applyStimulus(input bit v, input bit c, input int val);
    int   sum;
    exp_t e;
    @(negedge clk);
    in_vld  = v;
    clr     = c;
    incline = IN_W'(val);
    if (c) begin
      modelClear();
    end else if (v) begin
      modelBuf[modelPtr] = satModel(val);
      modelPtr           = (modelPtr + 1) % N;
      modelCount++;
      sum = 0;
      for (int i = 0; i < N; i++) sum += modelBuf[i];
      e.filt = sum >>> 2;
      e.hi   = (val > MAXV) ? 1 : 0;
      e.lo   = (val < MINV) ? 1 : 0;
      e.full = (modelCount >= N) ? 1 : 0;
      expQ.push_back(e);
    end
    @(posedge clk);
    #2;
    in_vld = 1'b0;
    clr    = 1'b0;
    if (v && !c) checkOutput("latency", expQ.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (out_vld === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_vld", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("filt", int'($signed(incline_filt)), monExp.filt);
        checkOutput("sat_hi", int'(sat_hi), monExp.hi);
        checkOutput("sat_lo", int'(sat_lo), monExp.lo);
        checkOutput("full", int'(full), monExp.full);
      end
    end
  end

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_vld"}, int'(out_vld), 0);
    checkOutput({tag, "_filt"}, int'($signed(incline_filt)), 0);
    checkOutput({tag, "_hi"}, int'(sat_hi), 0);
    checkOutput({tag, "_lo"}, int'(sat_lo), 0);
    checkOutput({tag, "_full"}, int'(full), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    in_vld  = 1'b0;
    incline = '0;
    modelClear();
    repeat (3) @(posedge clk);
    #2;
    checkIdleZero("reset");
`ifdef INCLINE_FILTER_SAT_STAT_EN
    checkOutput("reset_satcnt", int'(sat_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp from empty window: 25, 50, 75, 100, full on the fourth strobe.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 100);
    checkOutput("ramp_final", int'($signed(incline_filt)), 100);
    checkOutput("ramp_full", int'(full), 1);
    applyStimulus(1'b1, 1'b0, 300);
    applyStimulus(1'b0, 1'b0, 0);

    // Asynchronous reset between edges with a sample pending on the input.
    @(negedge clk);
    in_vld  = 1'b1;
    incline = IN_W'(777);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleZero("async_rst");
    modelClear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    rst_n  = 1'b1;
    applyStimulus(1'b1, 1'b0, 40);

    // Positive clip, then negative clip, then a moderate negative clip.
    modelClear();
    applyStimulus(1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4095);
    checkOutput("pos_clip_final", int'($signed(incline_filt)), 511);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, -4096);
    checkOutput("neg_clip_final", int'($signed(incline_filt)), -512);
    applyStimulus(1'b1, 1'b0, -600);
    checkOutput("neg600_lo", int'(sat_lo), 1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("hold_lo", int'(sat_lo), 1);
    checkOutput("hold_filt", int'($signed(incline_filt)), -512);

    // clr colliding with a valid sample drops the sample.
    applyStimulus(1'b1, 1'b1, 200);
    checkIdleZero("clr_collide");
    applyStimulus(1'b1, 1'b0, 200);
    checkOutput("after_clr", int'($signed(incline_filt)), 50);

    // Random samples with idle gaps, including out-of-range values.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'b0, int'($urandom_range(0, 8191)) - 4096);
    end

`ifdef INCLINE_FILTER_SAT_STAT_EN
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("satcnt_clr0", int'(sat_cnt), 0);
    applyStimulus(1'b1, 1'b0, 4095);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, -4096);
    applyStimulus(1'b1, 1'b0, -5);
    applyStimulus(1'b1, 1'b0, 1000);
    checkOutput("satcnt_3", int'(sat_cnt), 3);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("satcnt_clr", int'(sat_cnt), 0);
`endif

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
